// File: rtl/debounce_edge_counter.sv
// Debounce filter with edge pulses and a saturating rising-event counter.
// The input is already synchronised upstream. A new level is accepted only
// after it has been sampled on DEBOUNCE_CYCLES consecutive clock edges.
// All outputs come straight from flops.
module debounce_edge_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   sync_in,
  input  logic                   clear,
  output logic                   stable_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]          CNT_ZERO = CW'(0);
  localparam logic [COUNT_WIDTH-1:0] EVT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] EVT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic                     stable_q;
  logic                     rise_q;
  logic                     fall_q;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic [COUNT_WIDTH-1:0]   count_d;
  logic                     ovf_q;
  logic                     ovf_d;
  logic                     rise_evt_s;

  // A rising transition is accepted on the edge that completes a high run.
  assign rise_evt_s = (state_q == ST_CHK_HIGH) && sync_in && (cnt_q == CNT_LAST);

  // Debounce FSM; stable level and pulses are registered alongside the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_LOW;
      cnt_q    <= CNT_ZERO;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          if (sync_in) begin
            state_q <= ST_CHK_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= CNT_ZERO;
          end
        end
        ST_CHK_HIGH: begin
          if (!sync_in) begin
            // Glitch: fall back to the stable low level without a pulse.
            state_q <= ST_LOW;
            cnt_q   <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ST_HIGH;
            cnt_q    <= CNT_ZERO;
            stable_q <= 1'b1;
            rise_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sync_in) begin
            state_q <= ST_CHK_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= CNT_ZERO;
          end
        end
        ST_CHK_LOW: begin
          if (sync_in) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ST_LOW;
            cnt_q    <= CNT_ZERO;
            stable_q <= 1'b0;
            fall_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to the safe low state.
          state_q  <= ST_LOW;
          cnt_q    <= CNT_ZERO;
          stable_q <= 1'b0;
        end
      endcase
    end
  end

  // Next value of the event counter and sticky overflow; clear wins over a rise.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = {COUNT_WIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else if (rise_evt_s) begin
      if (count_q != EVT_MAX) begin
        count_d = count_q + EVT_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // Event counter and overflow registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= {COUNT_WIDTH{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stable_out  = stable_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_count = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_debounce_edge_counter.sv
// Directed bench for debounce_edge_counter (DEBOUNCE_CYCLES=4, COUNT_WIDTH=4).
module tb_debounce_edge_counter;

  logic       clk;
  logic       n_rst;
  logic       sync_in;
  logic       clear;
  logic       stable_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [3:0] event_count;
  logic       overflow;

  int n_checks;
  int n_pass;

  debounce_edge_counter #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sync_in    (sync_in),
    .clear      (clear),
    .stable_out (stable_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_count(event_count),
    .overflow   (overflow)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int n);
    sync_in = lvl;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0] pat;
  logic [7:0] pat_rise;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_rst    = 1'b0;
    sync_in  = 1'b0;
    clear    = 1'b0;
    #12;
    check_val("rst_stable", int'(stable_out), 0);
    check_val("rst_rise",   int'(rise_pulse), 0);
    check_val("rst_fall",   int'(fall_pulse), 0);
    check_val("rst_count",  int'(event_count), 0);
    check_val("rst_ovf",    int'(overflow), 0);
    n_rst = 1'b1;

    // Clean rising and falling edges.
    sync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("clean_rise_early", int'(rise_pulse), 0);
      check_val("clean_stable_early", int'(stable_out), 0);
    end
    step();
    check_val("clean_rise", int'(rise_pulse), 1);
    check_val("clean_stable1", int'(stable_out), 1);
    check_val("clean_count1", int'(event_count), 1);
    step();
    check_val("clean_rise_one_cycle", int'(rise_pulse), 0);
    check_val("clean_stable_hold", int'(stable_out), 1);
    sync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("clean_fall_early", int'(fall_pulse), 0);
      check_val("clean_stable_hi", int'(stable_out), 1);
    end
    step();
    check_val("clean_fall", int'(fall_pulse), 1);
    check_val("clean_rise_excl", int'(rise_pulse), 0);
    check_val("clean_stable0", int'(stable_out), 0);
    check_val("clean_count_after_fall", int'(event_count), 1);
    step();
    check_val("clean_fall_one_cycle", int'(fall_pulse), 0);

    // Asynchronous reset while high; no pulse on release.
    hold(1'b1, 4);
    check_val("pre_rst_count", int'(event_count), 2);
    check_val("pre_rst_stable", int'(stable_out), 1);
    #2 n_rst = 1'b0;
    #1;
    check_val("async_rst_stable", int'(stable_out), 0);
    check_val("async_rst_rise", int'(rise_pulse), 0);
    check_val("async_rst_count", int'(event_count), 0);
    #2 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("release_no_rise", int'(rise_pulse), 0);
      check_val("release_stable0", int'(stable_out), 0);
    end
    step();
    check_val("release_rise_4th", int'(rise_pulse), 1);
    check_val("release_count", int'(event_count), 1);

    // Glitches: 3-sample high run, then a low inside a high run.
    hold(1'b0, 5);
    check_val("glitch_pre_stable", int'(stable_out), 0);
    sync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("glitch3_rise", int'(rise_pulse), 0);
    end
    sync_in = 1'b0;
    step();
    check_val("glitch3_stable", int'(stable_out), 0);
    check_val("glitch3_rise_end", int'(rise_pulse), 0);
    hold(1'b0, 3);
    check_val("glitch3_count", int'(event_count), 1);
    pat      = 8'b1110_1111;   // applied msb first
    pat_rise = 8'b0000_0001;
    for (int i = 7; i >= 0; i--) begin
      sync_in = pat[i];
      step();
      check_val("glitch_pat_rise", int'(rise_pulse), int'(pat_rise[i]));
    end
    check_val("glitch_pat_count", int'(event_count), 2);

    // Clear does not disturb the FSM.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("clear_count", int'(event_count), 0);
    check_val("clear_stable", int'(stable_out), 1);

    // Saturation and overflow.
    for (int i = 1; i <= 16; i++) begin
      hold(1'b0, 4);
      hold(1'b1, 4);
      check_val("sat_count", int'(event_count), (i < 15) ? i : 15);
      check_val("sat_ovf", int'(overflow), (i >= 16) ? 1 : 0);
    end
    hold(1'b0, 4);
    check_val("ovf_sticky", int'(overflow), 1);
    check_val("fall_no_count", int'(event_count), 15);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("sat_clear_count", int'(event_count), 0);
    check_val("sat_clear_ovf", int'(overflow), 0);

    // Clear coincident with a rise event.
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 4);
      hold(1'b0, 4);
    end
    check_val("pre_coinc_count", int'(event_count), 5);
    hold(1'b1, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("coinc_rise", int'(rise_pulse), 1);
    check_val("coinc_stable", int'(stable_out), 1);
    check_val("coinc_count", int'(event_count), 0);
    check_val("coinc_ovf", int'(overflow), 0);

    // Reset during a falling check.
    hold(1'b0, 2);
    check_val("chk_low_stable", int'(stable_out), 1);
    #2 n_rst = 1'b0;
    #1;
    check_val("chk_low_rst_stable", int'(stable_out), 0);
    check_val("chk_low_rst_fall", int'(fall_pulse), 0);
    #2 n_rst = 1'b1;
    sync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("requal_no_rise", int'(rise_pulse), 0);
      check_val("requal_no_fall", int'(fall_pulse), 0);
    end
    step();
    check_val("requal_rise", int'(rise_pulse), 1);
    check_val("requal_count", int'(event_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_edge_counter.md
Name: debounce_edge_counter

Overview:
Consumes the 2-flop synchronized output of the input synchronizer stage. Debounces it with a cycle-count filter and produces a clean level plus single-cycle rise/fall pulses. Keeps a saturating count of qualified rising events for downstream control logic. Fully synchronous to clk; the input is already synchronized, so no metastability handling is needed here.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive sampled cycles at the new level required to accept a transition; legal range is >= 2
COUNT_WIDTH, 4, width of event_count

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
sync_in  input  1  synchronized input from the upstream synchronizer
clear  input  1  synchronous clear of event_count and overflow
stable_out  output  1  debounced level
rise_pulse  output  1  one-cycle pulse on an accepted 0->1 transition
fall_pulse  output  1  one-cycle pulse on an accepted 1->0 transition
event_count  output  COUNT_WIDTH  saturating count of accepted rising transitions
overflow  output  1  sticky flag: a rising event was dropped at saturation

Behaviour:
Interface: reset n_rst, asynchronous, active-low; clock clk. All outputs are registered.

Reset:
- FSM enters LOW; debounce counter = 0.
- stable_out, rise_pulse, fall_pulse, overflow all 0; event_count = 0.
- Reset mid-operation aborts any pending check immediately. No pulse is generated on reset release.

FSM states: LOW, CHK_HIGH, HIGH, CHK_LOW. Debounce counter width is clog2(DEBOUNCE_CYCLES+1).
- LOW: sync_in=1 -> CHK_HIGH with cnt=1. Otherwise stay in LOW.
- CHK_HIGH:
  - sync_in=0 -> LOW with cnt=0. This is a glitch; no pulse.
  - sync_in=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH with cnt=0.
  - Otherwise cnt+1.
- HIGH and CHK_LOW: mirror images of LOW and CHK_HIGH with polarity inverted.
- stable_out = 1 exactly in states HIGH and CHK_LOW.

Timing:
- With sync_in sampled at the new level on DEBOUNCE_CYCLES consecutive edges, the FSM changes state on the last of those edges.
- stable_out and the matching pulse become valid after that edge.
- The pulse is high for exactly one cycle, coincident with the first cycle of the new stable_out.
- Any opposite-level sample during a check restarts from the stable state. A run of DEBOUNCE_CYCLES-1 samples never produces a pulse.
- rise_pulse and fall_pulse are never high together.
- Minimum spacing between two pulses is DEBOUNCE_CYCLES cycles.

Event counter (updates on the same edge that asserts rise_pulse):
- clear=1 has highest priority: event_count=0 and overflow=0. A rise event on that same edge is discarded (not counted, overflow not set).
- Rise event with event_count < 2^COUNT_WIDTH-1: increment.
- Rise event with event_count at max: hold at max and set overflow=1.
- overflow stays set until clear or reset.
- Fall events never affect the counter.
- clear never affects the FSM, stable_out or the pulses.

Test Plan:
Defaults used throughout: DEBOUNCE_CYCLES=4, COUNT_WIDTH=4.
1. Reset: assert n_rst=0 mid-cycle with sync_in=1 -> all outputs 0 immediately, asynchronously; after release, sync_in held 1 for 4 edges -> rise_pulse only after the 4th edge, no pulse at release.
2. Glitch: sync_in high for 3 sampled edges then low -> stable_out stays 0, no rise_pulse, event_count=0; repeat with a 1-cycle low inside 6 highs -> no pulse until 4 uninterrupted highs.
3. Clean edges: sync_in 0->1 held 4 edges -> stable_out=1, rise_pulse high one cycle, event_count=1; then low held 4 edges -> fall_pulse one cycle, stable_out=0, event_count stays 1.
4. Saturation: 16 clean rising events -> event_count=15, overflow=0 after the 15th; overflow=1 after the 16th with count held at 15; clear=1 for one cycle -> event_count=0, overflow=0.
5. Simultaneous clear and rise: clear=1 on the rise_pulse edge with event_count=5 -> event_count=0, overflow=0, rise_pulse still emitted, stable_out=1.
6. Reset mid-check: n_rst pulsed low while in CHK_LOW -> stable_out=0 immediately, no fall_pulse; sync_in=1 afterwards -> full 4-edge rise qualification is required again.
